// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with req/ready/rvalid handshake, programmable wait states and window/size error reporting.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses instead of aligning them down.
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h8800_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + ({1'b0, 32'(DEPTH_WORDS)} << 2) - 33'd1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             a_we, a_uns;
    logic [1:0]       a_size;
    logic [31:0]      a_addr, a_wdata;
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range, misalign, bad, access, wr_en;
    logic [3:0]       be;
    logic [31:0]      wd, word, ld;

    // With zero wait states the access happens on the acceptance edge, so operands come straight from the ports.
    assign a_we    = (state_q == IDLE) ? we_i       : we_q;
    assign a_uns   = (state_q == IDLE) ? unsigned_i : uns_q;
    assign a_size  = (state_q == IDLE) ? size_i     : size_q;
    assign a_addr  = (state_q == IDLE) ? addr_i     : addr_q;
    assign a_wdata = (state_q == IDLE) ? wdata_i    : wdata_q;

    assign off      = a_addr - BASE_ADDR;
    assign idx      = IDX_W'(off >> 2);
    assign in_range = ({1'b0, a_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, a_addr} <= LAST_ADDR);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((a_size == 2'b01) && a_addr[0]) || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad   = ~in_range | (a_size == 2'b11) | misalign;
    assign wr_en = access & a_we & ~bad & ~rst_i;

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: if (req_i) begin
                if (WAIT_STATES == 0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end
            WAIT: if (cnt_q == 4'd0) begin
                access  = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        wd = a_wdata;
        ld = '0;
        word = mem_q[idx];
        unique case (a_size)
            2'b00: begin
                be = 4'b0001 << a_addr[1:0];
                wd = {4{a_wdata[7:0]}};
                ld = {{24{~a_uns & word[{a_addr[1:0], 3'b111}]}}, word[{a_addr[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                be = a_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
                ld = {{16{~a_uns & word[{a_addr[1], 4'b1111}]}}, word[{a_addr[1], 4'b0000} +: 16]};
            end
            2'b10: begin
                be = 4'b1111;
                ld = word;
            end
            default: be = 4'b0000;
        endcase
        rdata_d = (bad | a_we) ? 32'h0 : ld;
        err_d   = bad;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_i) begin
                we_q    <= we_i;
                uns_q   <= unsigned_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents must survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rvalid_o ? rdata_q : 32'h0;
    assign err_o    = rvalid_o & err_q;
endmodule
